inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Reader side of the instruction-memory interface. Owns the PC, drives a word address into
//  the combinational 48-bit instruction memory, captures the returned word into a small
//  fetch buffer and hands {instruction, PC} to decode over a valid/ready handshake.
//  Supports branch redirect with buffer flush. Sits between instruction memory and decode.
// PARAMETERS
//  INST_W     48  instruction width; equals memory data width
//  ADDR_W     48  address width of mem_addr, PC and redirect_pc
//  MEM_DEPTH  32  number of valid words; PC wraps modulo MEM_DEPTH
//  BUF_DEPTH   2  fetch buffer entries; power of 2, >=2
//  PC_RESET    0  PC value loaded at reset
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       synchronous reset, active-high
//  mem_addr        out  ADDR_W  word address to instruction memory; equals PC register
//  mem_data        in   INST_W  combinational read data for mem_addr, same cycle
//  fetch_en        in   1       1 = fetching allowed; 0 = PC frozen, buffer still drains
//  redirect_valid  in   1       1-cycle request to restart fetch at redirect_pc
//  redirect_pc     in   ADDR_W  redirect target (word address)
//  inst_valid      out  1       buffer head valid
//  inst_ready      in   1       decode accepts head when inst_valid & inst_ready
//  inst_data       out  INST_W  instruction at buffer head
//  inst_pc         out  ADDR_W  address inst_data was fetched from
//  addr_err        out  1       1-cycle pulse: redirect_pc >= MEM_DEPTH
//  stall_cnt       out  16      only with INST_FETCH_STALL_CNT_EN
// BEHAVIOUR
//  Reset (rst=1 at edge): PC<=PC_RESET; buffer empty; inst_valid=0, inst_data=0, inst_pc=0,
//   addr_err=0, stall_cnt=0. mem_addr=PC_RESET one cycle after reset.
//  Word addressing: memory indexed directly by mem_addr; next PC = (PC==MEM_DEPTH-1)?0:PC+1.
//  Fetch condition per cycle: fetch = fetch_en & ~redirect_valid & (count<BUF_DEPTH | deq),
//   deq = inst_valid & inst_ready. On fetch: push {mem_data, PC}, advance PC.
//  Simultaneous push and pop allowed, including when full; count unchanged.
//  Latency: word at PC appears on inst_valid/inst_data the cycle after its fetch edge;
//   first instruction valid 1 cycle after the first edge with rst=0 and fetch_en=1.
//  Buffer empty: inst_valid=0, inst_data/inst_pc hold last head value. Full without deq:
//   PC holds, mem_addr stable, no push.
//  Outputs stable while inst_valid & ~inst_ready.
//  Redirect (highest priority after rst): buffer flushed (count<=0, inst_valid=0 next cycle);
//   no push that cycle; a pop that cycle is discarded as part of the flush.
//   PC<=redirect_pc if < MEM_DEPTH; else PC<=0 and addr_err=1 for that one cycle.
//   Fetch resumes next cycle if fetch_en=1.
//  Back-to-back redirects: each flushes; last one wins.
//  rst mid-operation: overrides redirect and fetch; all state returns to reset values.
//  No FSM beyond buffer count; pointers wrap modulo BUF_DEPTH.
// CONFIGURATION
//  INST_FETCH_STALL_CNT_EN defined: stall_cnt increments, saturating at 16'hFFFF, each cycle
//   fetch_en=1, no redirect, buffer full and no deq; cleared by rst only.
//  Not defined: stall_cnt port absent; no counter logic.
// TESTING  (memory model: [0]=0x0001, [1]=0x58CE00000FFA, [10]=0x8063, [14]=0x1456, others 0)
//  Reset release, fetch_en=1, inst_ready=1 -> outputs (pc,data) (0,0x0001), (1,0x58CE00000FFA), (2,0) on consecutive cycles.
//  inst_ready=0 for 5 cycles -> exactly 2 entries buffered, PC held at 2, head (0,0x0001) stable;
//   with macro, stall_cnt=3 at end of the 5 cycles.
//  Redirect to 10 while buffer full -> next cycle inst_valid=0; following cycle head (10,0x8063),
//   then (11,0); old entries never emitted.
//  Redirect to 31, ready=1 -> (31,0) then wrap to (0,0x0001); redirect to 40 -> addr_err pulse, next head (0,0x0001).
//  rst asserted while redirect_valid=1 to 14 -> reset wins: PC=0, inst_valid=0; redirect ignored.
//  Random ready/fetch_en/redirects vs reference model -> in-order, no loss/dup, inst_pc matches data.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC owner and fetch buffer between instruction memory and decode.
// Optional stall counter enabled by defining INST_FETCH_STALL_CNT_EN.
module inst_fetch_unit #(
    parameter int                INST_W    = 48,
    parameter int                ADDR_W    = 48,
    parameter int                MEM_DEPTH = 32,
    parameter int                BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] PC_RESET  = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_data,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
`ifdef INST_FETCH_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              addr_err
);

    localparam int                PTR_W    = $clog2(BUF_DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(BUF_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              addr_err_q, addr_err_d;
    logic [INST_W-1:0] hold_data_q;
    logic [ADDR_W-1:0] hold_pc_q;

    logic [INST_W-1:0] buf_data_q [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc_q   [BUF_DEPTH];

    logic              deq;
    logic              full;
    logic              fetch;
    logic [ADDR_W-1:0] pc_seq;
    logic [INST_W-1:0] head_data;
    logic [ADDR_W-1:0] head_pc;

    assign inst_valid = (count_q != '0);
    assign head_data  = buf_data_q[rd_ptr_q];
    assign head_pc    = buf_pc_q[rd_ptr_q];
    assign deq        = inst_valid & inst_ready;
    assign full       = (count_q == FULL_CNT);
    assign fetch      = fetch_en & ~redirect_valid & (~full | deq);
    assign pc_seq     = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_W'(1);

    // When empty, the last head shown to decode is held on the outputs.
    assign inst_data  = inst_valid ? head_data : hold_data_q;
    assign inst_pc    = inst_valid ? head_pc   : hold_pc_q;
    assign mem_addr   = pc_q;
    assign addr_err   = addr_err_q;

    always_comb begin
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        addr_err_d = 1'b0;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (redirect_pc < DEPTH_A) begin
                pc_d = redirect_pc;
            end else begin
                pc_d       = '0;
                addr_err_d = 1'b1;
            end
        end else begin
            if (fetch) begin
                pc_d     = pc_seq;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({fetch, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= PC_RESET;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            addr_err_q  <= 1'b0;
            hold_data_q <= '0;
            hold_pc_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            addr_err_q <= addr_err_d;
            if (inst_valid) begin
                hold_data_q <= head_data;
                hold_pc_q   <= head_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fetch) begin
            buf_data_q[wr_ptr_q] <= mem_data;
            buf_pc_q[wr_ptr_q]   <= pc_q;
        end
    end

`ifdef INST_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (fetch_en && !redirect_valid && full && !deq && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed and random checks of inst_fetch_unit against a queue model.
module tb_inst_fetch_unit;

    typedef struct packed {
        logic [47:0] data;
        logic [47:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] mem_addr;
    logic [47:0] mem_data;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [47:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [47:0] inst_data;
    logic [47:0] inst_pc;
    logic        addr_err;
`ifdef INST_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    ent_t        sbq[$];
    ent_t        mlast;
    logic [47:0] mpc;
    logic        merr;
    logic [15:0] mstall;

    always #5 clk = ~clk;

    function automatic logic [47:0] memf(input logic [47:0] a);
        case (a)
            48'd0:   return 48'h0001;
            48'd1:   return 48'h58CE00000FFA;
            48'd10:  return 48'h8063;
            48'd14:  return 48'h1456;
            default: return 48'h0;
        endcase
    endfunction

    assign mem_data = memf(mem_addr);

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
`ifdef INST_FETCH_STALL_CNT_EN
        .stall_cnt      (stall_cnt),
`endif
        .addr_err       (addr_err)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [47:0] pc, input logic [47:0] data);
        check({tag, "_valid"}, 96'(inst_valid), 96'(1'b1));
        check({tag, "_pc"}, 96'(inst_pc), 96'(pc));
        check({tag, "_data"}, 96'(inst_data), 96'(data));
    endtask

    // Reference model: queue of fetched-but-unconsumed entries, updated at each edge.
    always @(posedge clk) begin
        bit mdeq;
        bit mfetch;
        if (rst) begin
            sbq.delete();
            mpc    = '0;
            merr   = 1'b0;
            mlast  = '0;
            mstall = '0;
        end else begin
            if (sbq.size() != 0) mlast = sbq[0];
            mdeq = (sbq.size() != 0) && inst_ready;
            if (redirect_valid) begin
                sbq.delete();
                merr = (redirect_pc >= 48'd32);
                mpc  = merr ? 48'd0 : redirect_pc;
            end else begin
                merr   = 1'b0;
                mfetch = fetch_en && ((sbq.size() < 2) || mdeq);
                if (fetch_en && sbq.size() == 2 && !mdeq && mstall != 16'hFFFF) mstall++;
                if (mdeq) void'(sbq.pop_front());
                if (mfetch) begin
                    sbq.push_back('{data: memf(mpc), pc: mpc});
                    mpc = (mpc == 48'd31) ? 48'd0 : mpc + 48'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_valid", 96'(inst_valid), 96'(sbq.size() != 0));
            if (sbq.size() != 0) begin
                check("mon_head", {inst_data, inst_pc}, sbq[0]);
            end else begin
                check("mon_hold", {inst_data, inst_pc}, mlast);
            end
            check("mon_mem_addr", 96'(mem_addr), 96'(mpc));
            check("mon_addr_err", 96'(addr_err), 96'(merr));
`ifdef INST_FETCH_STALL_CNT_EN
            check("mon_stall", 96'(stall_cnt), 96'(mstall));
`endif
        end
    end

    initial begin
        tick;
        tick;
        mon_en = 1'b1;
        check("rst_valid", 96'(inst_valid), 96'(1'b0));
        check("rst_data", 96'(inst_data), 96'(0));
        check("rst_pc", 96'(inst_pc), 96'(0));
        check("rst_addr_err", 96'(addr_err), 96'(0));
        check("rst_mem_addr", 96'(mem_addr), 96'(0));
`ifdef INST_FETCH_STALL_CNT_EN
        check("rst_stall", 96'(stall_cnt), 96'(0));
`endif

        rst = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
        tick; expect_head("first0", 48'd0, 48'h0001);
        tick; expect_head("first1", 48'd1, 48'h58CE00000FFA);
        tick; expect_head("first2", 48'd2, 48'h0);

        rst = 1'b1;
        tick;
        rst = 1'b0; inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            expect_head("stall_head", 48'd0, 48'h0001);
        end
        check("stall_mem_addr", 96'(mem_addr), 96'(2));
`ifdef INST_FETCH_STALL_CNT_EN
        check("stall_cnt3", 96'(stall_cnt), 96'(3));
`endif

        redirect_valid = 1'b1; redirect_pc = 48'd10; inst_ready = 1'b1;
        tick;
        check("redir10_flush", 96'(inst_valid), 96'(0));
        check("redir10_addr", 96'(mem_addr), 96'(10));
        redirect_valid = 1'b0;
        tick; expect_head("redir10_a", 48'd10, 48'h8063);
        tick; expect_head("redir10_b", 48'd11, 48'h0);

        redirect_valid = 1'b1; redirect_pc = 48'd31;
        tick;
        check("redir31_flush", 96'(inst_valid), 96'(0));
        redirect_valid = 1'b0;
        tick; expect_head("redir31_a", 48'd31, 48'h0);
        tick; expect_head("redir31_wrap", 48'd0, 48'h0001);

        redirect_valid = 1'b1; redirect_pc = 48'd40;
        tick;
        check("redir40_err", 96'(addr_err), 96'(1));
        check("redir40_pc", 96'(mem_addr), 96'(0));
        check("redir40_flush", 96'(inst_valid), 96'(0));
        redirect_valid = 1'b0;
        tick;
        check("redir40_err_end", 96'(addr_err), 96'(0));
        expect_head("redir40_head", 48'd0, 48'h0001);

        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 48'd14;
        tick;
        check("rst_redir_valid", 96'(inst_valid), 96'(0));
        check("rst_redir_pc", 96'(mem_addr), 96'(0));
        check("rst_redir_err", 96'(addr_err), 96'(0));
        rst = 1'b0; redirect_valid = 1'b0;
        tick; expect_head("rst_redir_head", 48'd0, 48'h0001);

        for (int i = 0; i < 600; i++) begin
            fetch_en       = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 48'($urandom_range(0, 40));
            rst            = ($urandom_range(0, 149) == 0);
            tick;
        end

        rst = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0; inst_ready = 1'b1;
        repeat (4) tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
